// File: rtl/regfile_writeback_if.sv
// Writeback bundle: ALU and load result handshakes in, register file write port and
// pending-load mask out. The design side uses the slave modport.
interface regfile_writeback_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();
  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_addr;
  logic [DATA_W-1:0]        alu_data;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [ADDR_W-1:0]        ld_addr;
  logic [DATA_W-1:0]        ld_data;
  logic                     rf_wr;
  logic [ADDR_W-1:0]        rf_addr_wr;
  logic [DATA_W-1:0]        rf_data_wr;
  logic [(2**ADDR_W)-1:0]   pend_mask;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready, rf_wr, rf_addr_wr, rf_data_wr, pend_mask
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready, rf_wr, rf_addr_wr, rf_data_wr, pend_mask
  );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback stage: merges ALU results and queued load results onto the single register file
// write port. Optional feature macro WB_LOAD_BYPASS_EN sends a load straight to the port when idle.
module regfile_writeback #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst,
  regfile_writeback_if.slave wb
);

  localparam int unsigned PtrW    = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CntW    = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [PtrW:0]   QFull     = (PtrW + 1)'(LQ_DEPTH);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  // Queue storage is qualified by q_vld_q, so the data arrays need no reset.
  logic [ADDR_W-1:0]   q_addr [LQ_DEPTH];
  logic [DATA_W-1:0]   q_data [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] q_vld_q, q_vld_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]       count_q, count_d;
  logic [CntW-1:0]     starve_cnt_q, starve_cnt_d;

  logic                rf_wr_q, rf_wr_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;

  logic q_empty, q_full, alu_live, starve, grant_ld;
  logic alu_ready, ld_ready, ld_live, bypass, alu_wr, push, pop;
  logic [NumRegs-1:0] pend;

  always_comb begin
    q_empty  = (count_q == '0);
    q_full   = (count_q == QFull);
    alu_live = wb.alu_valid && (wb.alu_addr != '0);
    starve   = (starve_cnt_q == StarveMax);
    grant_ld = !q_empty && (!alu_live || q_full || starve);
    alu_ready = !rst && !(!q_empty && (q_full || starve));
    ld_ready  = !rst && !q_full;
    // Register-0 beats are accepted by the handshake but go nowhere.
    ld_live   = wb.ld_valid && ld_ready && (wb.ld_addr != '0);
`ifdef WB_LOAD_BYPASS_EN
    bypass    = q_empty && !alu_live && ld_live;
`else
    bypass    = 1'b0;
`endif
    alu_wr    = alu_live && alu_ready && !grant_ld;
    push      = ld_live && !bypass;
    pop       = grant_ld;
  end

  always_comb begin
    rf_wr_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (grant_ld) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = q_addr[rd_ptr_q];
      rf_data_d = q_data[rd_ptr_q];
    end else if (alu_wr) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = wb.alu_addr;
      rf_data_d = wb.alu_data;
    end else if (bypass) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = wb.ld_addr;
      rf_data_d = wb.ld_data;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    q_vld_d  = q_vld_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + 1'b1;
      q_vld_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      q_vld_d[wr_ptr_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Counts ALU wins against a waiting load; reaching StarveMax forces the next load grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (q_empty || grant_ld) begin
      starve_cnt_d = '0;
    end else if (alu_wr && !starve) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (q_vld_q[i]) begin
        pend[q_addr[i]] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      q_vld_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      rf_wr_q      <= rf_wr_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      q_vld_q      <= q_vld_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr_q] <= wb.ld_addr;
      q_data[wr_ptr_q] <= wb.ld_data;
    end
  end

  assign wb.alu_ready  = alu_ready;
  assign wb.ld_ready   = ld_ready;
  assign wb.rf_wr      = rf_wr_q;
  assign wb.rf_addr_wr = rf_addr_q;
  assign wb.rf_data_wr = rf_data_q;
  assign wb.pend_mask  = pend;

endmodule
